// File: rtl/mm_arbiter.sv
// Main-memory arbiter for the I-cache and D-cache controllers.
// One requester owns main memory at a time: I/D line-refill bursts of WORDS
// beats, or a single D-side word write. Ties are broken round-robin on the
// side that was not granted last. Each transaction ends with one RELEASE
// cycle that pulses the owner's done output.
module mm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mm_re,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic              mm_valid,
    input  logic [DATA_W-1:0] mm_rdata
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int OFF    = BEAT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D_RD,
        S_GRANT_D_WR,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_last_d;   // 1: D was granted last (and owns the current transaction)
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_pick_i;
    logic                w_rd;
    logic                w_beat_last;

    assign w_i_req     = i_re;
    assign w_d_req     = d_re | d_we;
    // I wins when it is alone or when D held the previous grant.
    assign w_pick_i    = w_i_req & (~w_d_req | r_last_d);
    assign w_rd        = (r_state == S_GRANT_I) | (r_state == S_GRANT_D_RD);
    assign w_beat_last = (r_beat == BEAT_W'(WORDS - 1));

    // Returned read data is shared; only the valid strobes are steered.
    assign i_rdata = mm_rdata;
    assign d_rdata = mm_rdata;

    // State register; async reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and output decode from the registered state.
    always_comb begin
        w_next   = r_state;
        mm_re    = 1'b0;
        mm_we    = 1'b0;
        mm_addr  = '0;
        mm_wdata = '0;
        i_valid  = 1'b0;
        d_valid  = 1'b0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_i) begin
                    w_next = S_GRANT_I;
                end else if (w_d_req) begin
                    w_next = d_we ? S_GRANT_D_WR : S_GRANT_D_RD;
                end
            end
            S_GRANT_I, S_GRANT_D_RD: begin
                mm_re   = 1'b1;
                mm_addr = {r_addr[ADDR_W-1:OFF], r_beat, 2'b00};
                i_valid = mm_valid & (r_state == S_GRANT_I);
                d_valid = mm_valid & (r_state == S_GRANT_D_RD);
                if (mm_valid && w_beat_last) begin
                    w_next = S_RELEASE;
                end
            end
            S_GRANT_D_WR: begin
                mm_we    = 1'b1;
                mm_addr  = r_addr;
                mm_wdata = r_wdata;
                if (mm_valid) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                i_done = ~r_last_d;
                d_done = r_last_d;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Beat counter and round-robin owner; the beat counter wraps to 0 on the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat   <= '0;
            r_last_d <= 1'b1;
        end else begin
            if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
                r_last_d <= (w_next != S_GRANT_I);
            end
            if (w_rd && mm_valid) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Address and write data track the winner while idle and freeze once granted.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_addr  <= w_pick_i ? i_addr : d_addr;
            r_wdata <= d_wdata;
        end
    end

endmodule
